// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads a combinational instruction memory,
// and buffers {pc, instr} pairs in a 2-entry queue toward decode.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr
);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] q_pc    [2];
   logic [DATA_WIDTH-1:0] q_instr [2];
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            count;
   logic                  push;
   logic                  pop;

   assign imem_addr = pc;
   assign if_valid  = (count != 2'd0);
   assign if_pc     = if_valid ? q_pc[rd_ptr]    : '0;
   assign if_instr  = if_valid ? q_instr[rd_ptr] : '0;

   // A full queue still takes a new fetch when decode drains the head in the same cycle.
   assign pop  = if_valid & if_ready;
   assign push = fetch_en & ~redirect_valid & ((count < 2'd2) | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc & ~ADDR_WIDTH'(3);
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            pc     <= pc + ADDR_WIDTH'(4);
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         q_pc[wr_ptr]    <= pc;
         q_instr[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, instr} pairs are queued as
// fetches are expected and popped whenever decode accepts the head.
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, fetch_en, redirect_valid, if_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;
   logic        if_valid;

   logic        rst_w, fetch_en_w, if_ready_w, if_valid_w;
   logic [31:0] imem_addr_w, imem_rdata_w, if_pc_w, if_instr_w;

   logic [31:0] mem [64];
   exp_t        sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rdata   = mem[imem_addr[7:2]];
   assign imem_rdata_w = mem[imem_addr_w[7:2]];

   instr_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr));

   instr_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst_w), .fetch_en(fetch_en_w), .imem_addr(imem_addr_w),
      .imem_rdata(imem_rdata_w), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .if_valid(if_valid_w), .if_ready(if_ready_w), .if_pc(if_pc_w), .if_instr(if_instr_w));

   function automatic exp_t mk(input logic [31:0] a);
      mk.pc    = a;
      mk.instr = mem[a[7:2]];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the main DUT freshly reset with rst low and fetching enabled.
   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      fetch_en = 1'b1; if_ready = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: valid=%b pc=%h instr=%h addr=%h, required 0/0/0/0",
                  if_valid, if_pc, if_instr, imem_addr);
      end
   endtask

   task automatic test_sustained();
      exp_t e;
      do_reset();
      for (int i = 0; i < 4; i++) sb.push_back(mk(32'(i * 4)));
      for (int c = 0; c < 4; c++) begin
         tick();
         e = sb.pop_front();
         n_checks++;
         if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            n_fail++;
            $display("[TB] FAIL sustained[%0d]: valid=%b pc=%h instr=%h, required 1 pc=%h instr=%h",
                     c, if_valid, if_pc, if_instr, e.pc, e.instr);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      do_reset();
      if_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem[0]) begin
            n_fail++;
            $display("[TB] FAIL bp_hold[%0d]: valid=%b pc=%h instr=%h, required 1 pc=0 instr=%h",
                     c, if_valid, if_pc, if_instr, mem[0]);
         end
      end
      n_checks++;
      if (imem_addr !== 32'h8) begin
         n_fail++;
         $display("[TB] FAIL bp_pc_stall: addr=%h, required 00000008", imem_addr);
      end
      for (int i = 0; i < 6; i++) sb.push_back(mk(32'(i * 4)));
      if_ready = 1'b1;
      for (int c = 0; c < 20 && sb.size() > 0; c++) begin
         if (if_valid && if_ready) begin
            e = sb.pop_front();
            n_checks++;
            if (if_pc !== e.pc || if_instr !== e.instr) begin
               n_fail++;
               $display("[TB] FAIL bp_drain: pc=%h instr=%h, required pc=%h instr=%h",
                        if_pc, if_instr, e.pc, e.instr);
            end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL bp_timeout: %0d entries outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] targets [2];
      targets[0] = 32'h40;
      targets[1] = 32'h43;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         if_ready = 1'b0;
         tick();
         tick();
         redirect_valid = 1'b1; redirect_pc = targets[t]; if_ready = 1'b1;
         tick();
         redirect_valid = 1'b0; redirect_pc = '0;
         n_checks++;
         if (if_valid !== 1'b0 || imem_addr !== 32'h40) begin
            n_fail++;
            $display("[TB] FAIL redirect_flush[%h]: valid=%b addr=%h, required 0 addr=00000040",
                     targets[t], if_valid, imem_addr);
         end
         tick();
         n_checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem[16]) begin
            n_fail++;
            $display("[TB] FAIL redirect_resume[%h]: valid=%b pc=%h instr=%h, required 1 pc=00000040 instr=%h",
                     targets[t], if_valid, if_pc, if_instr, mem[16]);
         end
      end
   endtask

   task automatic test_fetch_en();
      exp_t e;
      do_reset();
      if_ready = 1'b0;
      tick();
      tick();
      fetch_en = 1'b0; if_ready = 1'b1;
      sb.push_back(mk(32'h0));
      sb.push_back(mk(32'h4));
      for (int c = 0; c < 10 && sb.size() > 0; c++) begin
         if (if_valid && if_ready) begin
            e = sb.pop_front();
            n_checks++;
            if (if_pc !== e.pc || if_instr !== e.instr) begin
               n_fail++;
               $display("[TB] FAIL en_drain: pc=%h instr=%h, required pc=%h instr=%h",
                        if_pc, if_instr, e.pc, e.instr);
            end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL en_timeout: %0d entries outstanding, required 0", sb.size());
         sb.delete();
      end
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (if_valid !== 1'b0 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("[TB] FAIL en_idle[%0d]: valid=%b addr=%h, required 0 addr=00000008",
                     c, if_valid, imem_addr);
         end
         tick();
      end
      fetch_en = 1'b1;
      tick();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2]) begin
         n_fail++;
         $display("[TB] FAIL en_resume: valid=%b pc=%h instr=%h, required 1 pc=00000008 instr=%h",
                  if_valid, if_pc, if_instr, mem[2]);
      end
   endtask

   task automatic test_pc_wrap();
      exp_t e;
      rst_w = 1'b1; fetch_en_w = 1'b1; if_ready_w = 1'b1;
      tick();
      rst_w = 1'b0;
      sb.push_back(mk(32'hFFFF_FFF8));
      sb.push_back(mk(32'hFFFF_FFFC));
      sb.push_back(mk(32'h0000_0000));
      for (int c = 0; c < 10 && sb.size() > 0; c++) begin
         if (if_valid_w && if_ready_w) begin
            e = sb.pop_front();
            n_checks++;
            if (if_pc_w !== e.pc || if_instr_w !== e.instr) begin
               n_fail++;
               $display("[TB] FAIL pc_wrap: pc=%h instr=%h, required pc=%h instr=%h",
                        if_pc_w, if_instr_w, e.pc, e.instr);
            end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL wrap_timeout: %0d entries outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      if_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b1;
      tick();
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      n_checks++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid: valid=%b addr=%h pc=%h instr=%h, required 0/0/0/0",
                  if_valid, imem_addr, if_pc, if_instr);
      end
   endtask

   initial begin
      rst = 1'b1; fetch_en = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      rst_w = 1'b1; fetch_en_w = 1'b0; if_ready_w = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113;
      mem[3] = 32'h0030_0193;
      tick();
      test_reset();
      test_sustained();
      test_backpressure();
      test_redirect();
      test_fetch_en();
      test_pc_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
